hdmi_audio_decimator: RTL and testbench



---
 rtl/hdmi_audio_pkg.sv | 23 ++
 rtl/hdmi_audio_avg_ring.sv | 41 ++++
 rtl/hdmi_audio_decimator.sv | 117 +++++++++++
 tb/tb_hdmi_audio_decimator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared types and helpers for the HDMI audio conditioning path.
package hdmi_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Clamp a wide signed value into the 16-bit PCM range.
  function automatic sample_t sat16(input logic signed [31:0] x);
    if (x > 32'sd32767) begin
      return sample_t'(16'sh7fff);
    end else if (x < -32'sd32768) begin
      return sample_t'(16'sh8000);
    end
    return sample_t'(x);
  endfunction

  // Phase accumulator width: holds acc + FS without wrapping, plus one guard bit.
  function automatic int acc_width(input int clk_hz, input int fs);
    return $clog2(clk_hz + fs) + 1;
  endfunction

endpackage

// File: rtl/hdmi_audio_avg_ring.sv
// One channel of the power-of-two moving average: sample ring plus running sum.
module hdmi_audio_avg_ring
  import hdmi_audio_pkg::*;
#(
  parameter int AVG_SH = 3
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_stb,
  input  logic [((AVG_SH == 0) ? 1 : AVG_SH)-1:0] wptr,
  input  logic [SAMPLE_W-1:0]                   din,
  output logic [SAMPLE_W-1:0]                   avg
);

  localparam int DEPTH = 1 << AVG_SH;
  localparam int SUM_W = SAMPLE_W + AVG_SH;

  sample_t                  ring [DEPTH];
  sample_t                  din_s;
  logic signed [SUM_W-1:0]  sum;

  assign din_s = din;

  // NOTE: the ring is a small register array, not a RAM macro, so it can and
  // must be cleared by reset; otherwise the running sum would start inconsistent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= '0;
      end
    end else if (in_stb) begin
      sum        <= sum + SUM_W'(din_s) - SUM_W'(ring[wptr]);
      ring[wptr] <= din_s;
    end
  end

  // Window sum of 2^AVG_SH in-range samples always fits, so truncation is exact.
  assign avg = SAMPLE_W'(sum >>> AVG_SH);

endmodule

// File: rtl/hdmi_audio_decimator.sv
// Stereo PCM moving-average filter re-timed onto an exact FS strobe.
// Optional DC blocker on the output path is enabled by defining DC_BLOCK_EN.
module hdmi_audio_decimator
  import hdmi_audio_pkg::*;
#(
  parameter int CLK_HZ = 28000000,
  parameter int FS     = 48000,
  parameter int AVG_SH = 3,
  parameter int DC_SH  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_stb,
  input  logic [SAMPLE_W-1:0] in_l,
  input  logic [SAMPLE_W-1:0] in_r,
  input  logic                mute,
  output logic [SAMPLE_W-1:0] out_l,
  output logic [SAMPLE_W-1:0] out_r,
  output logic                out_stb
);

  localparam int ACC_W = acc_width(CLK_HZ, FS);
  localparam int DEPTH = 1 << AVG_SH;
  localparam int PTR_W = (AVG_SH == 0) ? 1 : AVG_SH;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             tick;
  logic [PTR_W-1:0] wptr;
  sample_t          avg_l, avg_r;
  sample_t          val_l, val_r;

  // Fractional divider: FS ticks in every CLK_HZ clocks with zero drift.
  assign acc_sum = acc + ACC_W'(FS);
  assign tick    = (acc_sum >= ACC_W'(CLK_HZ));

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (tick) begin
      acc <= acc_sum - ACC_W'(CLK_HZ);
    end else begin
      acc <= acc_sum;
    end
  end

  // Both channels share one write pointer so their windows stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
    end else if (in_stb) begin
      wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
    end
  end

  hdmi_audio_avg_ring #(.AVG_SH(AVG_SH)) u_ring_l (
    .clk     (clk),
    .reset_n (reset_n),
    .in_stb  (in_stb),
    .wptr    (wptr),
    .din     (in_l),
    .avg     (avg_l)
  );

  hdmi_audio_avg_ring #(.AVG_SH(AVG_SH)) u_ring_r (
    .clk     (clk),
    .reset_n (reset_n),
    .in_stb  (in_stb),
    .wptr    (wptr),
    .din     (in_r),
    .avg     (avg_r)
  );

`ifdef DC_BLOCK_EN
  localparam int DC_W = SAMPLE_W + DC_SH;

  logic signed [DC_W-1:0] dc_acc_l, dc_acc_r;
  sample_t                dc_l, dc_r;

  assign dc_l  = sample_t'(dc_acc_l >>> DC_SH);
  assign dc_r  = sample_t'(dc_acc_r >>> DC_SH);
  assign val_l = sat16(32'(avg_l) - 32'(dc_l));
  assign val_r = sat16(32'(avg_r) - 32'(dc_r));

  // Leaky integrator tracks the DC level; it keeps running while muted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_acc_l <= '0;
      dc_acc_r <= '0;
    end else if (tick) begin
      dc_acc_l <= dc_acc_l + DC_W'(avg_l) - DC_W'(dc_l);
      dc_acc_r <= dc_acc_r + DC_W'(avg_r) - DC_W'(dc_r);
    end
  end
`else
  assign val_l = avg_l;
  assign val_r = avg_r;
`endif

  // The average seen here predates any same-cycle input update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_l   <= '0;
      out_r   <= '0;
      out_stb <= 1'b0;
    end else begin
      out_stb <= tick;
      if (tick) begin
        out_l <= mute ? '0 : val_l;
        out_r <= mute ? '0 : val_r;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_audio_decimator.sv
// Randomized self-checking bench for hdmi_audio_decimator against a behavioural model.
module tb_hdmi_audio_decimator;

  localparam int CLK_HZ = 100;
  localparam int FS     = 30;
  localparam int AVG_SH = 2;
  localparam int WIN    = 1 << AVG_SH;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_stb;
  logic [15:0] in_l, in_r;
  logic        mute;
  logic [15:0] out_l, out_r;
  logic        out_stb;

  always #5 clk = ~clk;

  hdmi_audio_decimator #(
    .CLK_HZ (CLK_HZ),
    .FS     (FS),
    .AVG_SH (AVG_SH),
    .DC_SH  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_stb  (in_stb),
    .in_l    (in_l),
    .in_r    (in_r),
    .mute    (mute),
    .out_l   (out_l),
    .out_r   (out_r),
    .out_stb (out_stb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the last WIN accepted samples and the clock count since reset.
  int     hist_l[$], hist_r[$];
  longint n;
  int     exp_l, exp_r, exp_stb;

  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int window_avg(input int h[$]);
    int s = 0;
    foreach (h[i]) s += h[i];
    return floor_div(s, WIN);
  endfunction

  // A tick falls on clock k when floor(k*FS/CLK_HZ) steps up.
  function automatic bit tick_at(input longint k);
    return ((k + 1) * FS) / CLK_HZ != (k * FS) / CLK_HZ;
  endfunction

  function automatic int rand_sample();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic model_reset();
    hist_l = {};
    hist_r = {};
    for (int i = 0; i < WIN; i++) begin
      hist_l.push_back(0);
      hist_r.push_back(0);
    end
    n       = 0;
    exp_l   = 0;
    exp_r   = 0;
    exp_stb = 0;
  endtask

  // Drive one clock of stimulus, advance the model, then compare on the falling edge.
  task automatic run_cycle(input bit stb, input int l, input int r, input bit m);
    in_stb = stb;
    in_l   = l[15:0];
    in_r   = r[15:0];
    mute   = m;
    if (tick_at(n)) begin
      exp_stb = 1;
      exp_l   = m ? 0 : window_avg(hist_l);
      exp_r   = m ? 0 : window_avg(hist_r);
    end else begin
      exp_stb = 0;
    end
    if (stb) begin
      hist_l.push_back(l);
      void'(hist_l.pop_front());
      hist_r.push_back(r);
      void'(hist_r.pop_front());
    end
    n++;
    @(negedge clk);
    check("out_stb", 32'(out_stb), exp_stb);
    check("out_l", 32'($signed(out_l)), exp_l);
    check("out_r", 32'($signed(out_r)), exp_r);
  endtask

  initial begin
    int pulses, last_pulse, guard, muted, density;
    bit m;

    reset_n = 1'b0;
    in_stb  = 1'b0;
    in_l    = '0;
    in_r    = '0;
    mute    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_l", 32'(out_l), 0);
    check("reset_out_r", 32'(out_r), 0);
    check("reset_out_stb", 32'(out_stb), 0);

    reset_n = 1'b1;
    model_reset();

    // Idle input: pulse count and spacing over exactly 1000 clocks.
    pulses     = 0;
    last_pulse = -1;
    for (int k = 0; k < 1000; k++) begin
      run_cycle(1'b0, 0, 0, 1'b0);
      if (out_stb) begin
        if (last_pulse >= 0)
          check("stb_gap_3_or_4", 32'((k - last_pulse == 3) || (k - last_pulse == 4)), 1);
        last_pulse = k;
        pulses++;
      end
    end
    check("tick_count_1000", pulses, 300);

    // Random traffic: strobe density from sparse to every clock, mute in runs.
    m = 1'b0;
    for (int seg = 0; seg < 30; seg++) begin
      density = $urandom_range(0, 100);
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, 19) == 0) m = ~m;
        run_cycle($urandom_range(1, 100) <= density, rand_sample(), rand_sample(), m);
      end
    end

    // Steady tone, then mute for exactly five output strobes.
    for (int k = 0; k < 40; k++) run_cycle(k[0], 4096, -4096, 1'b0);
    muted = 0;
    guard = 0;
    while (muted < 5 && guard < 100) begin
      run_cycle(guard[0], 4096, -4096, 1'b1);
      if (out_stb) begin
        muted++;
        check("muted_out_l", 32'($signed(out_l)), 0);
      end
      guard++;
    end
    check("mute_ticks_seen", muted, 5);
    guard = 0;
    do begin
      run_cycle(1'b1, 4096, -4096, 1'b0);
      guard++;
    end while (!out_stb && guard < 20);
    check("unmute_stb", 32'(out_stb), 1);
    check("unmute_out_l", 32'($signed(out_l)), 4096);
    check("unmute_out_r", 32'($signed(out_r)), -4096);

    // Full-scale constants must settle without wrapping.
    for (int k = 0; k < 40; k++) run_cycle(1'b1, -32768, 32767, 1'b0);
    check("extreme_out_l", 32'(out_l), 32'h8000);
    check("extreme_out_r", 32'(out_r), 32'h7fff);

    // Asynchronous reset mid-stream, then the ramp-up from a cleared ring.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_l", 32'(out_l), 0);
    check("async_rst_out_r", 32'(out_r), 0);
    check("async_rst_out_stb", 32'(out_stb), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 300; k++)
      run_cycle($urandom_range(0, 1) == 1, rand_sample(), rand_sample(), $urandom_range(0, 9) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
